// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic {
        StBlank = 1'b0,
        StShow  = 1'b1
    } scan_state_e;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low one-hot anode strobe for a digit index.
    function automatic logic [3:0] an_strobe(input logic [DIGIT_W-1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/bin4_to_7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module bin4_to_7seg (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        unique case (i_nib)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan with per-digit blanking gap and frame-aligned value buffer.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] val,
    input  logic        val_load,
    input  logic [3:0]  digit_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned MaxTicks = (TICKS_PER_DIGIT > BLANK_TICKS) ?
                                       TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
    localparam logic [TickW-1:0] BlankLast = TickW'(BLANK_TICKS - 1);
    localparam logic [TickW-1:0] ShowLast  = TickW'(TICKS_PER_DIGIT - 1);

    scan_state_e        r_state, w_state_d;
    logic [DIGIT_W-1:0] r_digit, w_digit_d;
    logic [TickW-1:0]   r_tick,  w_tick_d;

    logic [15:0] r_active, r_pending;
    logic        r_pend_valid;

    logic [3:0] w_lzb_mask, w_digit_on;
    logic [3:0] w_nibble;
    logic [6:0] w_seg_dec;
    logic       w_show_d;
    logic [3:0] w_an_d;
    logic [6:0] w_seg_d;
    logic       w_fd_d;

    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_frame_done;

    always_comb begin
        w_state_d = r_state;
        w_digit_d = r_digit;
        w_tick_d  = r_tick + TickW'(1);
        unique case (r_state)
            StBlank: begin
                if (r_tick == BlankLast) begin
                    w_state_d = StShow;
                    w_tick_d  = '0;
                end
            end
            StShow: begin
                if (r_tick == ShowLast) begin
                    w_state_d = StBlank;
                    w_digit_d = r_digit + DIGIT_W'(1);
                    w_tick_d  = '0;
                end
            end
            default: begin
                w_state_d = StBlank;
                w_tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StBlank;
            r_digit <= '0;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_d;
            r_digit <= w_digit_d;
            r_tick  <= w_tick_d;
        end
    end

    // r_frame_done marks the boundary cycle; a load on that same cycle waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if (r_frame_done && r_pend_valid) begin
                r_active <= r_pending;
            end
            if (val_load) begin
                r_pending    <= val;
                r_pend_valid <= 1'b1;
            end else if (r_frame_done) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        w_lzb_mask    = 4'b0001;
        w_lzb_mask[3] = |r_active[15:12];
        w_lzb_mask[2] = |r_active[15:8];
        w_lzb_mask[1] = |r_active[15:4];
    end
`else
    assign w_lzb_mask = 4'b1111;
`endif

    assign w_digit_on = digit_en & w_lzb_mask;
    assign w_nibble   = r_active[4*w_digit_d +: 4];

    bin4_to_7seg u_dec (
        .i_nib (w_nibble),
        .o_seg (w_seg_dec)
    );

    // Outputs are decoded from next-state so they switch on the same edge as the FSM.
    always_comb begin
        w_show_d = (w_state_d == StShow) && w_digit_on[w_digit_d];
        w_an_d   = w_show_d ? an_strobe(w_digit_d) : AN_OFF;
        w_seg_d  = w_show_d ? w_seg_dec : SEG_OFF;
        w_fd_d   = (w_state_d == StShow) && (w_digit_d == LAST_DIGIT) && (w_tick_d == ShowLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_d;
            r_seg        <= w_seg_d;
            r_frame_done <= w_fd_d;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller with TICKS_PER_DIGIT=4, BLANK_TICKS=2 (24-cycle frame).
module tb_seg_scan_controller;

    localparam int unsigned Tpd   = 4;
    localparam int unsigned Blank = 2;
    localparam int unsigned Slot  = Tpd + Blank;
    localparam int unsigned Frame = 4 * Slot;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val = '0;
    logic        val_load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan_controller #(
        .TICKS_PER_DIGIT (Tpd),
        .BLANK_TICKS     (Blank)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .val        (val),
        .val_load   (val_load),
        .digit_en   (digit_en),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned load_cyc_q[$];
    logic [15:0] load_val_q[$];
    int unsigned t = 0;
    logic [3:0]  en_prev = 4'hF;
    bit          checking = 1'b0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference segment set per hex digit, by lit segment letters.
    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        string lit;
        logic [6:0] s = 7'h7F;
        case (nib)
            4'h0: lit = "abcdef";
            4'h1: lit = "bc";
            4'h2: lit = "abdeg";
            4'h3: lit = "abcdg";
            4'h4: lit = "bcfg";
            4'h5: lit = "acdfg";
            4'h6: lit = "acdefg";
            4'h7: lit = "abc";
            4'h8: lit = "abcdefg";
            4'h9: lit = "abcdfg";
            4'hA: lit = "abcefg";
            4'hB: lit = "cdefg";
            4'hC: lit = "adef";
            4'hD: lit = "bcdeg";
            4'hE: lit = "adefg";
            default: lit = "aefg";
        endcase
        for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
        return s;
    endfunction

    // Value shown in a frame: the latest load captured at least two cycles before it starts.
    function automatic logic [15:0] model_active(input int unsigned frame);
        logic [15:0] v = '0;
        if (frame > 0) begin
            for (int i = 0; i < load_cyc_q.size(); i++)
                if (load_cyc_q[i] <= Frame * frame - 2) v = load_val_q[i];
        end
        return v;
    endfunction

    function automatic exp_t expect_at(input int unsigned tt, input logic [3:0] en);
        int unsigned c    = tt % Frame;
        int unsigned slot = c / Slot;
        logic [15:0] act  = model_active(tt / Frame);
        logic [3:0]  eff  = en;
        exp_t e;
`ifdef SEG_SCAN_LZB_EN
        for (int i = 1; i < 4; i++) if ((act >> (4 * i)) == 16'h0) eff[i] = 1'b0;
`endif
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.fd  = (c == Frame - 1);
        if ((c % Slot) >= Blank && eff[slot]) begin
            e.an  = ~(4'b0001 << slot);
            e.seg = seg_of(act[4*slot +: 4]);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (checking && !rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (an !== e.an || seg !== e.seg || frame_done !== e.fd) begin
                miscompares++;
                $display("FAIL scan t=%0d: an/seg/frame_done got %b/%h/%b want %b/%h/%b",
                         t, an, seg, frame_done, e.an, e.seg, e.fd);
            end
        end
    end

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] en);
        exp_q.push_back(expect_at(t, en_prev));
        val_load = ld;
        val      = v;
        digit_en = en;
        if (ld) begin
            load_cyc_q.push_back(t);
            load_val_q.push_back(v);
        end
        en_prev = en;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < n; i++) step(1'b0, val, digit_en);
    endtask

    task automatic run_to(input int unsigned c);
        while ((t % Frame) != c) step(1'b0, val, digit_en);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        load_cyc_q.delete();
        load_val_q.delete();
        checking = 1'b1;
    endtask

    task automatic mid_reset();
        run_to(2 * Slot + Blank + 1);
        exp_q.push_back(expect_at(t, en_prev));
        #6;
        rst = 1'b1;
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: an/seg/frame_done got %b/%h/%b want 1111/7f/0",
                     an, seg, frame_done);
        end
        @(posedge clk);
        release_reset();
    endtask

    initial begin
        val_load = 1'b0;
        digit_en = 4'hF;
        en_prev  = 4'hF;
        repeat (2) @(posedge clk);
        release_reset();

        step(1'b1, 16'h1234, 4'hF);
        idle(2 * Frame - 1);

        run_to(3);
        step(1'b1, 16'hAAAA, 4'hF);
        run_to(10);
        step(1'b1, 16'h0005, 4'hF);
        idle(Frame);

        run_to(Frame - 1);
        step(1'b1, 16'h00FF, 4'hF);
        idle(2 * Frame);

        run_to(0);
        for (int i = 0; i < 2 * Frame; i++) step(1'b0, val, 4'b0101);
        for (int i = 0; i < 2; i++) step(1'b0, val, 4'hF);

        step(1'b1, 16'h0040, 4'hF);
        idle(2 * Frame);

        for (int i = 0; i < 10 * Frame; i++) begin
            logic       ld = ($urandom_range(0, 15) == 0);
            logic [3:0] en = digit_en;
            if ($urandom_range(0, 19) == 0) en = 4'($urandom);
            step(ld, ld ? 16'($urandom) : val, en);
        end

        step(1'b1, 16'h9E7C, 4'hF);
        idle(Frame);
        mid_reset();
        idle(2 * Frame);
        step(1'b1, 16'h0B0D, 4'hF);
        idle(2 * Frame);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
